// File: rtl/pitch_axi_lite_read_master.sv
// AXI4-Lite read-only master with a single-entry user command port and
// an optional periodic auto-poll of a fixed address.
//
// Ports:
//   m00_axi_aclk, m00_axi_areset   clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_addr   user read request (accepted only in IDLE)
//   poll_en                        enable automatic reads of POLL_ADDR
//   rsp_valid                      one-cycle response strobe
//   rsp_rdata/rsp_resp             read data and AXI response code
//   rsp_timeout                    transaction abandoned after TIMEOUT_CYCLES
//   rsp_poll                       response belongs to an automatic poll
//   m00_axi_ar*/m00_axi_r*         AXI4-Lite read address / read data channels
module pitch_axi_lite_read_master #(
    parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M00_AXI_ADDR_WIDTH = 4,
    parameter int unsigned TIMEOUT_CYCLES       = 64,
    parameter int unsigned POLL_PERIOD          = 1000,
    parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] POLL_ADDR = '0
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_areset,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic                            poll_en,

    output logic                            rsp_valid,
    output logic [C_M00_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            rsp_poll,

    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [2:0]                      m00_axi_arprot,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready
);

    localparam int unsigned DW   = C_M00_AXI_DATA_WIDTH;
    localparam int unsigned AW   = C_M00_AXI_ADDR_WIDTH;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PC_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(POLL_PERIOD - 1);
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] poll_cnt, poll_cnt_n, poll_cnt_inc;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic            cur_poll, cur_poll_n;
    logic [AW-1:0]   addr_n;
    logic [DW-1:0]   rdata_n;
    logic [1:0]      resp_n;
    logic            timeout_n;
    logic            rsp_poll_n;
    logic            poll_due;
    logic            ar_hs;
    logic            r_hs;

    assign m00_axi_arprot = 3'b000;

    assign poll_due     = poll_en && (poll_cnt == PC_LAST);
    assign poll_cnt_inc = (poll_cnt == PC_LAST) ? poll_cnt : poll_cnt + PC_W'(1);
    assign ar_hs        = m00_axi_arvalid && m00_axi_arready;
    assign r_hs         = m00_axi_rvalid && m00_axi_rready;

    // Next-state, counters and response capture.
    always_comb begin
        state_n    = state;
        poll_cnt_n = poll_cnt;
        to_cnt_n   = to_cnt;
        cur_poll_n = cur_poll;
        addr_n     = m00_axi_araddr;
        rdata_n    = rsp_rdata;
        resp_n     = rsp_resp;
        timeout_n  = rsp_timeout;
        rsp_poll_n = rsp_poll;

        case (state)
            IDLE: begin
                to_cnt_n = '0;
                if (cmd_valid && cmd_ready) begin
                    // A due poll stays pending: the saturated counter just holds.
                    addr_n     = cmd_addr;
                    cur_poll_n = 1'b0;
                    poll_cnt_n = poll_cnt_inc;
                    state_n    = AR;
                end else if (poll_due && !cmd_valid) begin
                    addr_n     = POLL_ADDR;
                    cur_poll_n = 1'b1;
                    poll_cnt_n = '0;
                    state_n    = AR;
                end else begin
                    poll_cnt_n = poll_cnt_inc;
                end
            end

            AR: begin
                to_cnt_n = to_cnt + TO_W'(1);
                if (ar_hs) begin
                    state_n = R;
                end else if (to_cnt == TO_LAST) begin
                    state_n    = RSP;
                    rdata_n    = '0;
                    resp_n     = RESP_SLVERR;
                    timeout_n  = 1'b1;
                    rsp_poll_n = cur_poll;
                end
            end

            R: begin
                to_cnt_n = to_cnt + TO_W'(1);
                if (r_hs) begin
                    state_n    = RSP;
                    rdata_n    = m00_axi_rdata;
                    resp_n     = m00_axi_rresp;
                    timeout_n  = 1'b0;
                    rsp_poll_n = cur_poll;
                end else if (to_cnt == TO_LAST) begin
                    state_n    = RSP;
                    rdata_n    = '0;
                    resp_n     = RESP_SLVERR;
                    timeout_n  = 1'b1;
                    rsp_poll_n = cur_poll;
                end
            end

            RSP: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        if (!poll_en) begin
            poll_cnt_n = '0;
        end
    end

    // State, counters and registered outputs; handshake outputs follow the next state.
    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state           <= IDLE;
            poll_cnt        <= '0;
            to_cnt          <= '0;
            cur_poll        <= 1'b0;
            cmd_ready       <= 1'b0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
            m00_axi_araddr  <= '0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= '0;
            rsp_timeout     <= 1'b0;
            rsp_poll        <= 1'b0;
        end else begin
            state           <= state_n;
            poll_cnt        <= poll_cnt_n;
            to_cnt          <= to_cnt_n;
            cur_poll        <= cur_poll_n;
            cmd_ready       <= (state_n == IDLE);
            m00_axi_arvalid <= (state_n == AR);
            m00_axi_rready  <= (state_n == R);
            m00_axi_araddr  <= addr_n;
            rsp_valid       <= (state_n == RSP);
            rsp_rdata       <= rdata_n;
            rsp_resp        <= resp_n;
            rsp_timeout     <= timeout_n;
            rsp_poll        <= rsp_poll_n;
        end
    end

endmodule

// File: tb/tb_pitch_axi_lite_read_master.sv
module tb_pitch_axi_lite_read_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam logic [AW-1:0] P_ADDR = 4'hC;

    logic          clk;
    logic          areset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          poll_en;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic          rsp_poll;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int n_pass = 0;
    int n_checks = 0;

    pitch_axi_lite_read_master #(
        .C_M00_AXI_DATA_WIDTH(DW),
        .C_M00_AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(8),
        .POLL_PERIOD(4),
        .POLL_ADDR(P_ADDR)
    ) dut (
        .m00_axi_aclk   (clk),
        .m00_axi_areset (areset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .poll_en        (poll_en),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_resp       (rsp_resp),
        .rsp_timeout    (rsp_timeout),
        .rsp_poll       (rsp_poll),
        .m00_axi_araddr (araddr),
        .m00_axi_arprot (arprot),
        .m00_axi_arvalid(arvalid),
        .m00_axi_arready(arready),
        .m00_axi_rdata  (rdata),
        .m00_axi_rresp  (rresp),
        .m00_axi_rvalid (rvalid),
        .m00_axi_rready (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave with programmable AR/R delays.
    int            sl_ar_delay = 0;
    int            sl_r_delay  = 0;
    logic          sl_never_r  = 1'b0;
    logic [DW-1:0] sl_data     = '0;
    logic [1:0]    sl_resp     = 2'b00;
    int            ar_cnt;
    int            r_cnt;
    logic          r_pend;

    assign arready = arvalid && (ar_cnt >= sl_ar_delay);
    assign rvalid  = r_pend && !sl_never_r && (r_cnt >= sl_r_delay);
    assign rdata   = rvalid ? sl_data : '0;
    assign rresp   = rvalid ? sl_resp : 2'b00;

    always @(posedge clk) begin
        if (areset) begin
            ar_cnt <= 0;
            r_cnt  <= 0;
            r_pend <= 1'b0;
        end else begin
            if (arvalid && arready) begin
                ar_cnt <= 0;
                r_pend <= 1'b1;
                r_cnt  <= 0;
            end else begin
                if (arvalid) ar_cnt <= ar_cnt + 1;
                if (r_pend) begin
                    if (rvalid && rready) r_pend <= 1'b0;
                    else                  r_cnt  <= r_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Waits (bounded) for rsp_valid, counting cycles from the launch cycle.
    task automatic wait_rsp(input logic [AW-1:0] exp_addr, output int lat,
                            output int arv_cycles, output logic addr_stable);
        lat = 0;
        arv_cycles = 0;
        addr_stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            if (arvalid) begin
                arv_cycles++;
                if (araddr !== exp_addr) addr_stable = 1'b0;
            end
        end
    endtask

    task automatic issue_cmd(input string tag, input logic [AW-1:0] addr);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input int lat, input int exp_lat,
                             input logic [DW-1:0] exp_data, input logic [1:0] exp_resp,
                             input logic exp_to, input logic exp_poll);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_data));
        check({tag, "_resp"}, 64'(rsp_resp), 64'(exp_resp));
        check({tag, "_timeout"}, 64'(rsp_timeout), 64'(exp_to));
        check({tag, "_poll"}, 64'(rsp_poll), 64'(exp_poll));
        @(negedge clk);
        check({tag, "_one_cycle"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rdata_hold"}, 64'(rsp_rdata), 64'(exp_data));
    endtask

    int   lat;
    int   arv;
    logic stable;

    initial begin
        areset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        poll_en   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_arprot", 64'(arprot), 64'd0);
        areset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Ideal slave.
        sl_data = 32'h0012_3456;
        issue_cmd("ideal", 4'h0);
        wait_rsp(4'h0, lat, arv, stable);
        check("ideal_arv_cycles", 64'(arv), 64'd1);
        check("ideal_araddr", 64'(stable), 64'd1);
        check_rsp("ideal", lat, 3, 32'h0012_3456, 2'b00, 1'b0, 1'b0);

        // AR and R each delayed one cycle.
        sl_ar_delay = 1;
        sl_r_delay  = 1;
        sl_data     = 32'hA5A5_0F0F;
        issue_cmd("slow", 4'h6);
        wait_rsp(4'h6, lat, arv, stable);
        check("slow_arv_cycles", 64'(arv), 64'd2);
        check("slow_araddr", 64'(stable), 64'd1);
        check_rsp("slow", lat, 5, 32'hA5A5_0F0F, 2'b00, 1'b0, 1'b0);
        sl_ar_delay = 0;
        sl_r_delay  = 0;

        // SLVERR passes through untouched.
        sl_data = 32'hDEAD_BEEF;
        sl_resp = 2'b10;
        issue_cmd("slverr", 4'h3);
        wait_rsp(4'h3, lat, arv, stable);
        check_rsp("slverr", lat, 3, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0);
        sl_resp = 2'b00;

        // Command collides with a due poll: command first, then the poll.
        poll_en = 1'b1;
        sl_data = 32'h0000_0111;
        repeat (2) @(negedge clk);
        issue_cmd("collide", 4'h4);
        check("collide_araddr", 64'(araddr), 64'h4);
        wait_rsp(4'h4, lat, arv, stable);
        check_rsp("collide", lat, 3, 32'h0000_0111, 2'b00, 1'b0, 1'b0);
        sl_data = 32'h0000_0222;
        wait_rsp(P_ADDR, lat, arv, stable);
        poll_en = 1'b0;
        check("poll_arv_cycles", 64'(arv), 64'd1);
        check("poll_araddr", 64'(stable), 64'd1);
        check_rsp("poll", lat, 3, 32'h0000_0222, 2'b00, 1'b0, 1'b1);

        // Slave never answers: abandoned after 8 AR/R cycles.
        sl_never_r = 1'b1;
        sl_data    = 32'hFFFF_FFFF;
        issue_cmd("tmo", 4'h2);
        wait_rsp(4'h2, lat, arv, stable);
        check("tmo_rready", 64'(rready), 64'd0);
        check_rsp("tmo", lat, 9, 32'h0, 2'b10, 1'b1, 1'b0);
        check("tmo_rready_after", 64'(rready), 64'd0);

        // Reset while waiting in R.
        issue_cmd("rst_mid", 4'h5);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_in_r", 64'(rready), 64'd1);
        areset = 1'b1;
        @(negedge clk);
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid_rready", 64'(rready), 64'd0);
        check("rst_mid_arvalid", 64'(arvalid), 64'd0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_mid_araddr", 64'(araddr), 64'd0);
        check("rst_mid_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_mid_resp", 64'(rsp_resp), 64'd0);
        check("rst_mid_timeout", 64'(rsp_timeout), 64'd0);
        check("rst_mid_poll", 64'(rsp_poll), 64'd0);
        areset     = 1'b0;
        sl_never_r = 1'b0;
        @(negedge clk);
        check("rst_mid_cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
